// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-port arbiter/sequencer in front of the SDRAM
// controller's single valid/ready word port.
//
// Port 0 (instruction fetch) and port 1 (load/store) each present a
// valid/addr/wdata/wmask request (wmask == 0 means read) and receive
// rdata plus a one-cycle ready pulse on completion. The granted request
// is registered onto mem_valid/mem_addr/mem_wdata/mem_wmask and held
// constant until the controller pulses mem_ready. mem_rdata is returned
// only to the granted port, and only for reads.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pX_valid/addr/wdata/wmask request from port X (X = 0, 1)
//   pX_rdata, pX_ready        response to port X
//   mem_valid/addr/wdata/wmask  request to the controller (registered)
//   mem_rdata, mem_ready      response from the controller
//
// Build option: define SDRAM_ARB_RR_EN for round-robin arbitration;
// without it, port 1 has fixed priority over port 0.

module sdram_port_arbiter #(
    parameter int AW = 25,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_valid,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [3:0]    p0_wmask,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_ready,
    input  logic          p1_valid,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [3:0]    p1_wmask,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_ready,
    output logic          mem_valid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;
    logic          mem_valid_q, mem_valid_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wmask_q, mem_wmask_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          p0_ready_q, p0_ready_d;
    logic          p1_ready_q, p1_ready_d;
    logic          win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_ready_q  <= 1'b0;
            p1_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_ready_q  <= p0_ready_d;
            p1_ready_q  <= p1_ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        p0_ready_d  = p0_ready_q;
        p1_ready_d  = p1_ready_q;

`ifdef SDRAM_ARB_RR_EN
        // On a tie the port that was not served last wins; a lone
        // requester wins outright.
        if (p0_valid && p1_valid) begin
            win = ~last_q;
        end else begin
            win = p1_valid;
        end
`else
        win = p1_valid;
`endif

        case (state_q)
            IDLE: begin
                if (p0_valid || p1_valid) begin
                    mem_addr_d  = win ? p1_addr  : p0_addr;
                    mem_wdata_d = win ? p1_wdata : p0_wdata;
                    mem_wmask_d = win ? p1_wmask : p0_wmask;
                    mem_valid_d = 1'b1;
                    grant_d     = win;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // mem_* are held: the controller samples addr in
                // several of its own states.
                if (mem_ready) begin
                    if (mem_wmask_q == 4'b0000) begin
                        if (grant_q) begin
                            p1_rdata_d = mem_rdata;
                        end else begin
                            p0_rdata_d = mem_rdata;
                        end
                    end
                    if (grant_q) begin
                        p1_ready_d = 1'b1;
                    end else begin
                        p0_ready_d = 1'b1;
                    end
                    mem_valid_d = 1'b0;
                    last_d      = grant_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Requests are not sampled here, so a requester's
                // still-high valid is not granted a second time.
                p0_ready_d = 1'b0;
                p1_ready_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_ready  = p0_ready_q;
    assign p1_ready  = p1_ready_q;

endmodule
